// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and UART-TX-side handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0] REQ_VALID;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0] REQ_PAR_EN;
  logic [NUM_REQ-1:0] REQ_READY;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic TX_PAR_EN;
  logic TX_DATA_VALID;
  logic TX_BUSY;
  modport master (
    output REQ_VALID, REQ_DATA, REQ_PAR_EN, TX_BUSY,
    input REQ_READY, TX_DATA, TX_PAR_EN, TX_DATA_VALID
  );
  modport slave (
    input REQ_VALID, REQ_DATA, REQ_PAR_EN, TX_BUSY,
    output REQ_READY, TX_DATA, TX_PAR_EN, TX_DATA_VALID
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX among NUM_REQ sources; BUSY-rise timeout built only with `UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic CLK,
  input logic RST,
  uart_tx_arbiter_if.slave bus,
  output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
  output logic ACTIVE,
  output logic TIMEOUT_ERR
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, win, idx;
  logic [IW:0] s;
  logic [DATA_WIDTH-1:0] data_q, data_d, wdata;
  logic [NUM_REQ-1:0] ready;
  logic par_q, par_d, vld_q, vld_d, act_q, act_d, err_q, err_d, wpar, found, grant, tmo;
  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 4) begin : g_bad_cfg
    $error("uart_tx_arbiter: parameter out of range");
  end
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb cnt_d = (state_q == WAIT_BUSY && !bus.TX_BUSY) ? cnt_q + 1'b1 : '0;
  always_ff @(posedge CLK) cnt_q <= RST ? '0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    s = '0;
    idx = '0;
    win = ptr_q;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      s = {1'b0, ptr_q} + (IW+1)'(k);
      idx = s >= (IW+1)'(NUM_REQ) ? IW'(s - (IW+1)'(NUM_REQ)) : IW'(s);
      if (bus.REQ_VALID[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    grant = state_q == IDLE && found && !bus.TX_BUSY;
    wdata = '0;
    wpar = 1'b0;
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win) begin
        wdata = bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
        wpar = bus.REQ_PAR_EN[i];
        ready[i] = grant;
      end
    end
    err_d = state_q == WAIT_BUSY && !bus.TX_BUSY && tmo;
    case (state_q)
      IDLE: state_d = grant ? ISSUE : IDLE;
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = bus.TX_BUSY ? WAIT_DONE : err_d ? IDLE : WAIT_BUSY;
      default: state_d = bus.TX_BUSY ? WAIT_DONE : IDLE;
    endcase
    ptr_d = grant ? win : ptr_q;
    gid_d = grant ? win : gid_q;
    data_d = grant ? wdata : data_q;
    par_d = grant ? wpar : par_q;
    vld_d = state_d == ISSUE;
    act_d = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      gid_q <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      vld_q <= 1'b0;
      act_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      data_q <= data_d;
      par_q <= par_d;
      vld_q <= vld_d;
      act_q <= act_d;
      err_q <= err_d;
    end
  end
  assign bus.REQ_READY = ready;
  assign bus.TX_DATA = data_q;
  assign bus.TX_PAR_EN = par_q;
  assign bus.TX_DATA_VALID = vld_q;
  assign GRANT_ID = gid_q;
  assign ACTIVE = act_q;
  assign TIMEOUT_ERR = err_q;
endmodule
